// File: rtl/rom_burst_reader.sv
// Burst reader for a synchronous cs/rd/addr ROM: fetches COUNT words from BASE_ADDR onto a valid/ready stream.
// Optional running checksum of delivered words is built only when ROM_READER_CHECKSUM_EN is defined.
module rom_burst_reader #(
   parameter int ADDR_W = 4,
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [ADDR_W:0]   count,
   output logic              busy,
   output logic              done,
   output logic              cs,
   output logic              rd,
   output logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] rom_data,
   output logic [DATA_W-1:0] out_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              out_last,
   output logic [DATA_W-1:0] checksum,
   output logic [2:0]        fsm_state
);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_REQ  = 3'd1,
      S_WAIT = 3'd2,
      S_HOLD = 3'd3,
      S_DONE = 3'd4
   } state_t;

   localparam logic [ADDR_W:0]   MAX_COUNT = {1'b1, {ADDR_W{1'b0}}};
   localparam logic [ADDR_W:0]   ONE_R     = {{ADDR_W{1'b0}}, 1'b1};
   localparam logic [ADDR_W-1:0] ONE_A     = {{(ADDR_W-1){1'b0}}, 1'b1};

   state_t            state;
   logic [ADDR_W-1:0] cur_addr;
   logic [ADDR_W:0]   remaining;
   logic [ADDR_W:0]   count_clamped;
   logic              accept;

   assign count_clamped = (count > MAX_COUNT) ? MAX_COUNT : count;
   assign accept        = (state == S_HOLD) && out_valid && out_ready;
   assign fsm_state     = state;

   // Valid/ready: a word transfers on any posedge where out_valid && out_ready are both high;
   // out_valid and out_data stay unchanged until that edge, and out_ready is ignored elsewhere.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= S_IDLE;
         cur_addr  <= '0;
         remaining <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         cs        <= 1'b0;
         rd        <= 1'b0;
         addr      <= '0;
         out_data  <= '0;
         out_valid <= 1'b0;
         out_last  <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (start) begin
                  cur_addr  <= base_addr;
                  remaining <= count_clamped;
                  busy      <= 1'b1;
                  if (count_clamped == '0) begin
                     state <= S_DONE;
                     done  <= 1'b1;
                  end else begin
                     state <= S_REQ;
                     cs    <= 1'b1;
                     rd    <= 1'b1;
                     addr  <= base_addr;
                  end
               end
            end
            S_REQ: begin
               cs    <= 1'b0;
               rd    <= 1'b0;
               state <= S_WAIT;
            end
            // The ROM drives its registered word during this cycle only, so capture it now.
            S_WAIT: begin
               out_data  <= rom_data;
               out_valid <= 1'b1;
               out_last  <= (remaining == ONE_R);
               state     <= S_HOLD;
            end
            S_HOLD: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  out_last  <= 1'b0;
                  cur_addr  <= cur_addr + ONE_A;
                  remaining <= remaining - ONE_R;
                  if (remaining == ONE_R) begin
                     state <= S_DONE;
                     done  <= 1'b1;
                  end else begin
                     state <= S_REQ;
                     cs    <= 1'b1;
                     rd    <= 1'b1;
                     addr  <= cur_addr + ONE_A;
                  end
               end
            end
            S_DONE: begin
               done  <= 1'b0;
               busy  <= 1'b0;
               state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

`ifdef ROM_READER_CHECKSUM_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         checksum <= '0;
      end else if ((state == S_IDLE) && start) begin
         checksum <= '0;
      end else if (accept) begin
         checksum <= checksum + out_data;
      end
   end
`else
   assign checksum = '0;
`endif

endmodule

// File: tb/tb_rom_burst_reader.sv
// Bench for rom_burst_reader: behavioural 16x8 ROM, word-list reference model and scoreboard.
// Expected checksum follows ROM_READER_CHECKSUM_EN, so the same bench covers both builds.
module tb_rom_burst_reader;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic [3:0] base_addr;
   logic [4:0] count;
   logic       busy, done, cs, rd, out_valid, out_ready, out_last;
   logic [3:0] addr;
   logic [7:0] out_data, checksum;
   logic [2:0] fsm_state;
   wire  [7:0] rom_data;

   // clock / reset block
   always #5 clk = ~clk;

   rom_burst_reader #(.ADDR_W(4), .DATA_W(8)) dut (
      .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .count(count),
      .busy(busy), .done(done), .cs(cs), .rd(rd), .addr(addr), .rom_data(rom_data),
      .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
      .out_last(out_last), .checksum(checksum), .fsm_state(fsm_state)
   );

   // Synchronous ROM: registered read, drives the bus only in the cycle after a select.
   logic [7:0] mem [16];
   logic [7:0] rom_q = 8'h00;
   logic       rom_oe = 1'b0;
   always @(posedge clk) begin
      rom_oe <= cs && rd;
      if (cs && rd) rom_q <= mem[addr];
   end
   assign rom_data = rom_oe ? rom_q : 8'bz;

   int         n_checks = 0;
   int         n_err = 0;
   logic [7:0] exp_q[$];
   logic [7:0] exp_ck;
   int         cs_cycles, valid_cycles;
   bit         mon_en = 1'b0;
   bit         ready_hold = 1'b0;
   bit         ready_rand = 1'b0;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   // ready driver
   initial begin
      out_ready = 1'b1;
      forever begin
         @(posedge clk);
         #2;
         if (ready_hold)      out_ready = 1'b0;
         else if (ready_rand) out_ready = ($urandom_range(0, 2) != 0);
         else                 out_ready = 1'b1;
      end
   end

   // scoreboard / protocol monitor
   logic [7:0] prev_data;
   bit         prev_hold = 1'b0;
   logic [7:0] exp_w;
   always @(negedge clk) begin
      if (rst || !mon_en) begin
         prev_hold = 1'b0;
      end else begin
         if (cs || rd) begin
            cs_cycles++;
            chk("cs_eq_rd", cs, rd);
         end
         if (out_valid) valid_cycles++;
         if (prev_hold) chk("hold_stable", out_data, prev_data);
         prev_hold = out_valid && !out_ready;
         prev_data = out_data;
         if (out_valid && out_ready) begin
            chk("word_expected", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
               exp_w = exp_q.pop_front();
               chk("word_data", out_data, exp_w);
               chk("word_last", out_last, exp_q.size() == 0);
            end
         end
         if (done) begin
            chk("busy_in_done", busy, 1);
            chk("checksum", checksum, exp_ck);
         end
      end
   end

   task automatic run_burst(input logic [3:0] b, input logic [4:0] c, input bit poke, input bit stall);
      int n, t, st;
      logic [3:0] a;
      logic [7:0] sum;
      n = (c > 5'd16) ? 16 : int'(c);
      exp_q.delete();
      sum = 8'h00;
      for (int i = 0; i < n; i++) begin
         a = b + 4'(i);
         exp_q.push_back(mem[a]);
         sum = sum + mem[a];
      end
`ifdef ROM_READER_CHECKSUM_EN
      exp_ck = sum;
`else
      exp_ck = 8'h00;
`endif
      cs_cycles = 0;
      valid_cycles = 0;
      ready_hold = stall;
      mon_en = 1'b1;
      tick();
      start = 1'b1; base_addr = b; count = c;
      tick();
      start = 1'b0; base_addr = 4'($urandom); count = 5'($urandom);
      @(negedge clk);
      chk("busy_after_start", busy, 1);
      chk("cs_first_cycle", cs, n != 0);
      if (n == 0) begin
         chk("done_after_start", done, 1);
      end else begin
         @(negedge clk);
         chk("valid_edge1", out_valid, 0);
         @(negedge clk);
         if (!poke) chk("valid_edge2", out_valid, 1);
      end
      t = 0;
      st = 0;
      while (!done && t < 600) begin
         if (ready_hold && out_valid) st++;
         if (st >= 5) ready_hold = 1'b0;
         start = poke && (t == 1);
         @(negedge clk);
         t++;
      end
      start = 1'b0;
      chk("done_seen", done, 1);
      chk("queue_drained", exp_q.size(), 0);
      chk("rom_accesses", cs_cycles, n);
      if (n == 0) chk("no_valid", valid_cycles, 0);
      @(negedge clk);
      chk("done_pulse_end", done, 0);
      chk("busy_end", busy, 0);
      ready_hold = 1'b0;
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_cs"}, cs, 0);
      chk({tag, "_rd"}, rd, 0);
      chk({tag, "_addr"}, addr, 0);
      chk({tag, "_data"}, out_data, 0);
      chk({tag, "_valid"}, out_valid, 0);
      chk({tag, "_last"}, out_last, 0);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_done"}, done, 0);
      chk({tag, "_checksum"}, checksum, 0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int t;
      for (int i = 0; i < 16; i++) mem[i] = 8'($urandom_range(0, 255));
      mem[0] = 8'h0A; mem[1] = 8'h28; mem[2] = 8'h1E; mem[15] = 8'hA0;
      rst = 1'b1; start = 1'b0; base_addr = 4'h0; count = 5'h0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk_all_zero("reset");
      rst = 1'b0;

      run_burst(4'd0, 5'd3, 1'b0, 1'b0);
      run_burst(4'd15, 5'd2, 1'b0, 1'b0);
      run_burst(4'd1, 5'd2, 1'b0, 1'b1);
      run_burst(4'd7, 5'd0, 1'b0, 1'b0);
      run_burst(4'($urandom), 5'($urandom_range(17, 31)), 1'b0, 1'b0);
      run_burst(4'd4, 5'd5, 1'b1, 1'b0);

      // reset while a word is held
      mon_en = 1'b0;
      ready_hold = 1'b1;
      tick();
      start = 1'b1; base_addr = 4'($urandom); count = 5'd10;
      tick();
      start = 1'b0;
      t = 0;
      while (!out_valid && t < 20) begin
         @(negedge clk);
         t++;
      end
      chk("hold_reached", out_valid, 1);
      rst = 1'b1;
      @(negedge clk);
      chk_all_zero("mid_rst");
      repeat (3) begin
         @(negedge clk);
         chk("no_done_in_rst", done, 0);
      end
      rst = 1'b0;
      ready_hold = 1'b0;
      @(negedge clk);
      chk("no_done_after_rst", done, 0);
      chk("idle_after_rst", busy, 0);

      run_burst(4'd0, 5'd3, 1'b0, 1'b0);

      ready_rand = 1'b1;
      for (int k = 0; k < 12; k++)
         run_burst(4'($urandom), 5'($urandom_range(0, 20)), 1'($urandom_range(0, 1)), 1'b0);
      ready_rand = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule
